// File: rtl/branch_history_table_if.sv
// branch_history_table_if
//   Bundles the fetch-lookup and EX-training signals of the branch history
//   table.
//   master : IF/EX side. Drives the fetch and update requests and receives
//            the prediction.
//   slave  : the predictor itself.
// Signals:
//   fetch_valid/fetch_pc       fetch issued this cycle and its PC
//   if_stall                   IF holding; the prediction register freezes
//   predict                    registered prediction for the previous fetch
//   upd_valid/upd_pc/upd_taken resolved conditional branch from EX
interface branch_history_table_if #(
  parameter int unsigned PC_W = 32
);
  logic            fetch_valid;
  logic [PC_W-1:0] fetch_pc;
  logic            if_stall;
  logic            predict;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;

  modport master (
    output fetch_valid, fetch_pc, if_stall, upd_valid, upd_pc, upd_taken,
    input  predict
  );

  modport slave (
    input  fetch_valid, fetch_pc, if_stall, upd_valid, upd_pc, upd_taken,
    output predict
  );
endinterface

// File: rtl/branch_history_table.sv
// branch_history_table
//   Direction predictor made of tagged 2-bit saturating counters held in
//   flops. A fetch PC is looked up in the same cycle it is issued, and the
//   prediction is registered, so it shows up one cycle later. Resolved
//   branches from EX train the table. When a training write and a lookup hit
//   the same entry in the same cycle, the lookup sees the entry as it was
//   before the write.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears all valid bits and predict
//   bus  branch_history_table_if.slave (fetch lookup, prediction, training)
module branch_history_table #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned PC_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  branch_history_table_if.slave   bus
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned TAG_LO  = INDEX_W + 2;
  localparam int unsigned TAG_HI  = INDEX_W + TAG_W + 1;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [1:0]         r_ctr [ENTRIES];
  logic               r_predict;

  logic [INDEX_W-1:0] w_fidx;
  logic [TAG_W-1:0]   w_ftag;
  logic               w_fhit;
  logic               w_fpred;
  logic [INDEX_W-1:0] w_uidx;
  logic [TAG_W-1:0]   w_utag;
  logic               w_uhit;
  logic [1:0]         w_uctr;

  // PC[1:0] and the bits above the tag play no part in indexing or tagging.
  logic w_unused;
  assign w_unused = ^{bus.fetch_pc[1:0], bus.fetch_pc[PC_W-1:TAG_HI+1],
                      bus.upd_pc[1:0],   bus.upd_pc[PC_W-1:TAG_HI+1]};

  always_comb begin
    w_fidx  = bus.fetch_pc[INDEX_W+1:2];
    w_ftag  = bus.fetch_pc[TAG_HI:TAG_LO];
    w_fhit  = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
    w_fpred = w_fhit && r_ctr[w_fidx][1];

    w_uidx  = bus.upd_pc[INDEX_W+1:2];
    w_utag  = bus.upd_pc[TAG_HI:TAG_LO];
    w_uhit  = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    w_uctr  = r_ctr[w_uidx];
    if (bus.upd_taken) begin
      if (w_uctr != 2'b11) w_uctr = w_uctr + 2'd1;
    end else begin
      if (w_uctr != 2'b00) w_uctr = w_uctr - 2'd1;
    end
  end

  // Prediction register: reset beats stall, and stall beats a new fetch.
  always_ff @(posedge clk) begin
    if (rst)                  r_predict <= 1'b0;
    else if (bus.if_stall)    r_predict <= r_predict;
    else if (bus.fetch_valid) r_predict <= w_fpred;
    else                      r_predict <= 1'b0;
  end

  assign bus.predict = r_predict;

  // Only a taken miss allocates a new entry. A not-taken miss is dropped.
  always_ff @(posedge clk) begin
    if (rst)
      r_valid <= '0;
    else if (bus.upd_valid && !w_uhit && bus.upd_taken)
      r_valid[w_uidx] <= 1'b1;
  end

  // Tags and counters are not reset; they are gated by valid.
  always_ff @(posedge clk) begin
    if (!rst && bus.upd_valid) begin
      if (w_uhit) begin
        r_ctr[w_uidx] <= w_uctr;
      end else if (bus.upd_taken) begin
        r_tag[w_uidx] <= w_utag;
        r_ctr[w_uidx] <= 2'b10;
      end
    end
  end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Direction predictor supplying the `predict` bit consumed by the IF-stage pre-decode branch logic. It indexes a table of tagged 2-bit saturating counters with the fetch PC when a fetch is issued. It presents the registered prediction one cycle later, aligned with the ICache instruction return. The EX stage trains it with resolved conditional-branch outcomes.

## Interface
- `INDEX_W`, 6: table index width; 2^INDEX_W entries (64).
- `TAG_W`, 8: partial tag width stored per entry.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch_valid`  in  1  a fetch request is issued this cycle at `fetch_pc`.
- `fetch_pc`  in  `WORD`  PC of the issued fetch.
- `if_stall`  in  1  IF stage holding; freezes the prediction register.
- `predict`  out  1  registered prediction for the previously issued fetch PC; 1 = taken.
- `upd_valid`  in  1  EX reports a resolved conditional branch this cycle.
- `upd_pc`  in  `WORD`  PC of the resolved branch.
- `upd_taken`  in  1  resolved direction.

## Operation
- Index = PC[INDEX_W+1:2]; tag = PC[INDEX_W+TAG_W+1:INDEX_W+2]. PC[1:0] is ignored.
- Each entry holds `valid` (1b), `tag` (TAG_W), and `ctr` (2b). Counter states:
  - 00 strong-NT
  - 01 weak-NT
  - 10 weak-T
  - 11 strong-T
- Lookup: hit = valid & (tag == fetch tag). The predicted value is hit & ctr[1].
- Prediction register:
  - `rst` clears it to 0.
  - Else if `if_stall`, it holds.
  - Else if `fetch_valid`, it loads the predicted value.
  - Else it loads 0.
- Update when `upd_valid`, at the entry indexed by `upd_pc`:
  - Hit with taken: ctr = min(ctr+1, 3).
  - Hit with not-taken: ctr = max(ctr-1, 0).
  - Miss with taken: allocate. Set valid=1, tag=upd tag, ctr=10. Any previous occupant is replaced.
  - Miss with not-taken: no change; no allocation.
- Update is independent of `if_stall`.
- Reset clears every `valid` bit in the same cycle (flop array, not RAM). Counters and tags are don't-care after reset.

## Timing
- Lookup latency is 1 cycle. The `predict` bit for the fetch issued in cycle N is valid in cycle N+1 and stays stable through any `if_stall` cycles that follow.
- Update latency is 1 cycle: an update in cycle N is visible to a lookup issued in cycle N+1.
- Simultaneous lookup and update on the same index in the same cycle: the lookup uses the pre-update entry (read-before-write).
- Simultaneous `rst` and `upd_valid`: reset wins and no entry becomes valid.
- Simultaneous `rst` and `fetch_valid`: `predict` = 0 next cycle.
- Reset asserted mid-stall: `predict` = 0 next cycle. The stall hold does not override reset.
- No stall path from this block: it always accepts updates and lookups.
- Reset value of `predict`: 0.

## Test plan
- Cold lookup: release `rst`, fetch 0x1C000040 -> `predict` = 0 next cycle.
- Allocate and saturate:
  - Update 0x1C000040 taken -> next fetch of it predicts 1 (ctr=10).
  - Two more taken updates -> ctr=11.
  - One not-taken update -> still predicts 1 (ctr=10).
  - A second not-taken update -> predicts 0 (ctr=01).
  - Four more not-taken updates -> ctr stays 00.
- Tag alias: allocate 0x1C000040 taken, then fetch 0x1C004040 (same index, different tag) -> `predict` = 0. Update 0x1C004040 not-taken -> entry for 0x1C000040 still predicts 1.
- Same-cycle conflict: entry at ctr=01; in one cycle fetch and update the same PC taken -> `predict` = 0 next cycle. A refetch of the same PC -> `predict` = 1.
- Stall hold: fetch a hit-taken PC, then assert `if_stall` for 3 cycles with `fetch_valid` toggling on other PCs -> `predict` stays 1 for all 3 cycles. After `if_stall` drops, it reflects the next issued fetch.
- Reset mid-operation: with 10 entries allocated, pulse `rst` for 1 cycle concurrent with `upd_valid` -> all subsequent lookups predict 0 and the concurrent update is not retained.
